// File: rtl/imem_if.sv
// rtl/imem_if.sv - instruction memory request/acknowledge bus
//
// Carries the fetch request from fetch_unit to instruction memory.
//   imem_addr : fetch address (equals the PC while imem_req is high)
//   imem_req  : request, held until ack or timeout abort
//   imem_ack  : memory data valid this cycle
//   imem_data : instruction word, meaningful only when imem_ack is high
// master = fetch unit side, slave = memory side.
interface imem_if;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - SISC instruction fetch stage: PC, IR and imem fetch handshake
//
// Ports:
//   clk, rst_f            : clock, asynchronous active-low reset
//   fetch_start           : one-cycle pulse, starts a fetch of mem[pc]
//   pc_rst                : synchronous PC reset to RESET_PC, honoured in any state
//   pc_write/pc_sel/br_sel: branch commit (IDLE only), absolute or PC-relative
//   imem                  : instruction memory bus (master side)
//   fetch_done, fetch_err : completion pulse, and abort flag pulsed with it
//   seq_err               : sticky protocol error (command received while busy)
//   pc, ir                : program counter and instruction register
//   opcode/mm/rd/rs/rt/imm: instruction fields decoded from ir
module fetch_unit #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        fetch_start,
    input  logic        pc_rst,
    input  logic        pc_write,
    input  logic        pc_sel,
    input  logic        br_sel,
    imem_if.master      imem,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic        seq_err,
    output logic [15:0] pc,
    output logic [31:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  mm,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [15:0] imm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter holds the number of REQ cycles already spent without ack,
    // so the abort fires during the TIMEOUT-th REQ cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        seq_err_q, seq_err_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        seq_err_d = seq_err_q;

        case (state_q)
            IDLE: begin
                // PC update lands on the same edge that enters REQ, so a
                // simultaneous fetch uses the updated PC.
                if (pc_rst) begin
                    pc_d = RESET_PC;
                end else if (pc_write && pc_sel) begin
                    pc_d = br_sel ? ir_q[15:0] : pc_q + ir_q[15:0];
                end
                if (fetch_start) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                if (fetch_start || pc_write) begin
                    seq_err_d = 1'b1;
                end
                if (pc_rst) begin
                    pc_d    = RESET_PC;
                    state_d = IDLE;
                end else if (imem.imem_ack) begin
                    ir_d    = imem.imem_data;
                    pc_d    = pc_q + 16'd1;
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Abort: IR becomes NOOP, PC still advances past the slot.
                    ir_d    = '0;
                    pc_d    = pc_q + 16'd1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (fetch_start || pc_write) begin
                    seq_err_d = 1'b1;
                end
                if (pc_rst) begin
                    pc_d = RESET_PC;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = (state_q == REQ);

    // A pc_rst arriving in DONE cancels the completion pulse.
    assign fetch_done = (state_q == DONE) && !pc_rst;
    assign fetch_err  = fetch_done && err_q;
    assign seq_err    = seq_err_q;

    assign pc     = pc_q;
    assign ir     = ir_q;
    assign opcode = ir_q[31:28];
    assign mm     = ir_q[27:24];
    assign rd     = ir_q[23:20];
    assign rs     = ir_q[19:16];
    assign rt     = ir_q[15:12];
    assign imm    = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

    localparam int          TIMEOUT  = 15;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_rst = 1'b0;
    logic        pc_write = 1'b0;
    logic        pc_sel = 1'b0;
    logic        br_sel = 1'b0;
    logic        fetch_done, fetch_err, seq_err;
    logic [15:0] pc, imm;
    logic [31:0] ir;
    logic [3:0]  opcode, mm, rd, rs, rt;

    imem_if imem();

    fetch_unit #(.TIMEOUT(TIMEOUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_f(rst_f), .fetch_start(fetch_start), .pc_rst(pc_rst),
        .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel), .imem(imem),
        .fetch_done(fetch_done), .fetch_err(fetch_err), .seq_err(seq_err),
        .pc(pc), .ir(ir), .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt),
        .imm(imm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural PC and IR only.
    logic [15:0] m_pc;
    logic [31:0] m_ir;

    typedef struct {
        logic [31:0] ir;
        logic [15:0] pc;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    int   done_cnt = 0;

    // Monitor: every completion pulse must match the oldest expected fetch.
    always @(negedge clk) begin
        if (rst_f && fetch_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_fetch_done", {31'd0, fetch_done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_ir", ir, e.ir);
                check("done_pc", {16'd0, pc}, {16'd0, e.pc});
                check("done_err", {31'd0, fetch_err}, {31'd0, e.err});
                check("done_fields", {opcode, mm, rd, rs, rt, imm},
                      {e.ir[31:28], e.ir[27:24], e.ir[23:20], e.ir[19:16], e.ir[15:12], e.ir[15:0]});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // All tasks start and end at 1 time unit after a rising edge, in IDLE.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // delay = number of REQ cycles before ack (>= TIMEOUT means no ack in time).
    task automatic do_fetch(input int delay, input logic [31:0] data, input bit with_br,
                            input bit sel, input bit br, input bit poke);
        int          i;
        int          exp_n;
        bit          acked;
        logic [15:0] exp_addr, bad_addr;
        logic [31:0] new_ir;
        exp_t        e;
        if (with_br && sel) m_pc = br ? m_ir[15:0] : m_pc + m_ir[15:0];
        exp_addr = m_pc;
        acked    = (delay < TIMEOUT);
        exp_n    = acked ? delay + 1 : TIMEOUT;
        new_ir   = acked ? data : 32'd0;
        e.ir = new_ir; e.pc = m_pc + 16'd1; e.err = !acked;
        exp_q.push_back(e);

        fetch_start = 1'b1;
        pc_write = with_br; pc_sel = sel; br_sel = br;
        imem.imem_ack = 1'b0;
        step();
        fetch_start = 1'b0; pc_write = 1'b0;
        i = 0;
        bad_addr = exp_addr;
        while (imem.imem_req && i < 40) begin
            if (imem.imem_addr !== exp_addr) bad_addr = imem.imem_addr;
            imem.imem_ack  = (i == delay);
            imem.imem_data = (i == delay) ? data : $urandom;
            pc_write = poke && (i == 1);
            pc_sel   = 1'b1;
            br_sel   = 1'(i);
            step();
            i++;
        end
        pc_write = 1'b0;
        check("req_cycles", i, exp_n);
        check("imem_addr", {16'd0, bad_addr}, {16'd0, exp_addr});
        check("done_after_req", {31'd0, fetch_done}, 32'd1);
        // Acks outside REQ (in DONE and IDLE) must be ignored.
        imem.imem_ack = 1'($urandom_range(0, 1)); imem.imem_data = $urandom;
        step();
        imem.imem_ack = 1'b1; imem.imem_data = $urandom;
        step();
        imem.imem_ack = 1'b0;
        m_ir = new_ir;
        m_pc = m_pc + 16'd1;
        check("pc_after_fetch", {16'd0, pc}, {16'd0, m_pc});
        check("ir_after_fetch", ir, m_ir);
    endtask

    task automatic do_branch(input bit sel, input bit br);
        pc_write = 1'b1; pc_sel = sel; br_sel = br;
        step();
        pc_write = 1'b0;
        if (sel) m_pc = br ? m_ir[15:0] : m_pc + m_ir[15:0];
        check("pc_branch", {16'd0, pc}, {16'd0, m_pc});
    endtask

    int r, d;

    initial begin
        imem.imem_ack  = 1'b0;
        imem.imem_data = 32'd0;
        m_pc = RESET_PC;
        m_ir = 32'd0;
        #12;
        check("rst_pc", {16'd0, pc}, {16'd0, RESET_PC});
        check("rst_ir", ir, 32'd0);
        check("rst_outs", {28'd0, imem.imem_req, fetch_done, fetch_err, seq_err}, 32'd0);
        check("rst_fields", {opcode, mm, rd, rs, rt, imm}, 32'd0);
        rst_f = 1'b1;
        step();

        // Same-cycle ack, then delayed ack, then timeout.
        do_fetch(0, 32'h8123_0005, 0, 0, 0, 0);
        check("tp1_fields", {opcode, mm, rd, rs, imm}, {4'h8, 4'h1, 4'h2, 4'h3, 16'h0005});
        check("tp1_pc", {16'd0, pc}, 32'h0001);
        do_fetch(4, 32'h1234_5678, 0, 0, 0, 0);
        do_fetch(255, 32'hDEAD_BEEF, 0, 0, 0, 0);
        check("timeout_ir", ir, 32'd0);

        // Relative/absolute branch with imm=FFFE at pc=0010, then wrap.
        do_fetch(1, 32'h0000_000F, 0, 0, 0, 0);
        do_branch(1, 1);
        do_fetch(0, 32'h3000_FFFE, 0, 0, 0, 0);
        check("pc_0010", {16'd0, pc}, 32'h0010);
        do_branch(1, 0);
        check("pc_rel", {16'd0, pc}, 32'h000E);
        do_branch(1, 1);
        check("pc_abs", {16'd0, pc}, 32'hFFFE);
        do_branch(0, 1);
        check("pc_nosel", {16'd0, pc}, 32'hFFFE);
        do_fetch(2, 32'h5555_AAAA, 0, 0, 0, 0);
        do_fetch(0, 32'h0000_0001, 0, 0, 0, 0);
        check("pc_wrap", {16'd0, pc}, 32'h0000);

        // Randomized fetches with boundary delays and branches.
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            d = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? TIMEOUT - 1 : (r == 8) ? TIMEOUT : 255;
            do_fetch(d, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 2) == 0)
                do_branch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("seq_err_clean", {31'd0, seq_err}, 32'd0);

        // pc_write while busy: ignored, seq_err sticks.
        do_fetch(3, $urandom, 0, 0, 0, 1);
        check("seq_err_set", {31'd0, seq_err}, 32'd1);
        do_fetch(1, $urandom, 0, 0, 0, 0);
        check("seq_err_sticky", {31'd0, seq_err}, 32'd1);

        // pc_rst mid-REQ: abandon the fetch, no completion.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        pc_rst = 1'b1;
        step();
        pc_rst = 1'b0;
        m_pc = RESET_PC;
        check("pcrst_req", {31'd0, imem.imem_req}, 32'd0);
        check("pcrst_pc", {16'd0, pc}, {16'd0, m_pc});
        check("pcrst_ir", ir, m_ir);
        repeat (3) step();

        // Async reset mid-REQ, with an ack left hanging across release.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        #2 rst_f = 1'b0;
        #1;
        check("arst_outs", {28'd0, imem.imem_req, fetch_done, fetch_err, seq_err}, 32'd0);
        check("arst_pc_ir", {pc, ir[15:0]}, {RESET_PC, 16'd0});
        check("arst_ir", ir, 32'd0);
        imem.imem_ack = 1'b1; imem.imem_data = 32'hFFFF_FFFF;
        #2 rst_f = 1'b1;
        step();
        step();
        imem.imem_ack = 1'b0;
        m_pc = RESET_PC;
        m_ir = 32'd0;
        check("arst_ignore_ack", ir, 32'd0);
        check("arst_pc_after", {16'd0, pc}, {16'd0, m_pc});
        do_fetch(0, 32'h9ABC_DEF0, 0, 0, 0, 0);

        repeat (2) step();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
